// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } ctrl_state_e;

   // True when lo <= t < lo+k. Callers zero-extend their CNT_W+1 counter and
   // CNT_W count into 32 bits, so lo+k cannot wrap for any legal size.
   function automatic logic in_window(input int unsigned t,
                                      input int unsigned lo,
                                      input int unsigned k);
      return (t >= lo) && (t < lo + k);
   endfunction

endpackage

// File: rtl/skew_window_gen.sv
// Diagonal skew window decode: row feeder enables, per-PE partial-sum valid
// grid and south-edge valid strobes, all derived from the stream counter.
module skew_window_gen
   import systolic_ctrl_pkg::*;
#(
   parameter int unsigned ROW   = 4,
   parameter int unsigned COL   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic [CNT_W:0]     t_i,
   input  logic [CNT_W-1:0]   k_i,
   input  logic               stream_en_i,
   output logic [ROW-1:0]     x_row_en_o,
   output logic [ROW*COL-1:0] ps_valid_o,
   output logic [COL-1:0]     south_valid_o
);

   // Window compares against the latched vector count, gated by STREAM.
   always_comb begin
      x_row_en_o    = '0;
      ps_valid_o    = '0;
      south_valid_o = '0;
      if (stream_en_i) begin
         for (int unsigned r = 0; r < ROW; r++) begin
            x_row_en_o[r] = in_window(32'(t_i), r, 32'(k_i));
            for (int unsigned c = 0; c < COL; c++) begin
               ps_valid_o[r*COL+c] = in_window(32'(t_i), r + c, 32'(k_i));
            end
         end
         for (int unsigned c = 0; c < COL; c++) begin
            south_valid_o[c] = in_window(32'(t_i), ROW + c, 32'(k_i));
         end
      end
   end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, skewed activation
// stream, partial-sum drain. PE grid bit for [r][c] is index r*COL+c.
module systolic_array_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int unsigned ROW   = 4,
   parameter int unsigned COL   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [CNT_W-1:0]   num_vec_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               w_load_en_o,
   output logic [ROW-1:0]     x_row_en_o,
   output logic [ROW*COL-1:0] ctrl_load_o,
   output logic [ROW*COL-1:0] ctrl_sum_out_o,
   output logic [ROW*COL-1:0] ctrl_ps_in_o,
   output logic [ROW*COL-1:0] ctrl_ps_valid_o,
   output logic [COL-1:0]     south_valid_o
);

   localparam logic [CNT_W:0] LOAD_LAST = (CNT_W+1)'(ROW - 1);
   localparam logic [CNT_W:0] SKEW_LAST = (CNT_W+1)'(ROW + COL - 2);

   ctrl_state_e      state_q;
   logic [CNT_W:0]   t_q;
   logic [CNT_W-1:0] k_q;
   logic             busy_q;
   logic             done_q;
   logic             load_q;
   logic [CNT_W:0]   stream_last;
   logic [ROW*COL-1:0] ps_valid;
   logic [ROW*COL-1:0] row0_mask;

   // Last STREAM cycle index: K + ROW + COL - 2, fits in CNT_W+1 bits.
   assign stream_last = {1'b0, k_q} + SKEW_LAST;

   // Sequencer FSM with counter, latched K and registered simple outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         t_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  t_q    <= '0;
                  if (num_vec_i != '0) begin
                     k_q     <= num_vec_i;
                     load_q  <= 1'b1;
                     state_q <= LOAD;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            LOAD: begin
               if (t_q == LOAD_LAST) begin
                  t_q     <= '0;
                  load_q  <= 1'b0;
                  state_q <= STREAM;
               end else begin
                  t_q <= t_q + 1'b1;
               end
            end
            STREAM: begin
               if (t_q == stream_last) begin
                  t_q     <= '0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  t_q <= t_q + 1'b1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               load_q  <= 1'b0;
               t_q     <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   skew_window_gen #(
      .ROW   (ROW),
      .COL   (COL),
      .CNT_W (CNT_W)
   ) u_skew (
      .t_i           (t_q),
      .k_i           (k_q),
      .stream_en_i   (state_q == STREAM),
      .x_row_en_o    (x_row_en_o),
      .ps_valid_o    (ps_valid),
      .south_valid_o (south_valid_o)
   );

   // Row 0 never takes a north carry-in.
   always_comb begin
      row0_mask = '1;
      for (int unsigned c = 0; c < COL; c++) begin
         row0_mask[c] = 1'b0;
      end
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign w_load_en_o     = load_q;
   assign ctrl_load_o     = {(ROW*COL){load_q}};
   assign ctrl_ps_valid_o = ps_valid;
   assign ctrl_sum_out_o  = ps_valid;
   assign ctrl_ps_in_o    = ps_valid & row0_mask;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench: each accepted job pushes its full expected per-cycle
// output trace (stamped with the cycle it must appear in); a monitor pops
// one entry every busy cycle and checks idle cycles are all-zero.
module tb_systolic_array_ctrl;

   localparam int ROW   = 4;
   localparam int COL   = 4;
   localparam int CNT_W = 8;
   localparam int N     = ROW * COL;

   typedef struct packed {
      logic           busy;
      logic           done;
      logic           wload;
      logic [ROW-1:0] xrow;
      logic [N-1:0]   load;
      logic [N-1:0]   sum;
      logic [N-1:0]   psin;
      logic [N-1:0]   psv;
      logic [COL-1:0] south;
   } snap_t;

   typedef struct {
      snap_t       s;
      int unsigned cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic [CNT_W-1:0] num_vec_i = '0;
   logic             busy_o, done_o, w_load_en_o;
   logic [ROW-1:0]   x_row_en_o;
   logic [N-1:0]     ctrl_load_o, ctrl_sum_out_o, ctrl_ps_in_o, ctrl_ps_valid_o;
   logic [COL-1:0]   south_valid_o;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   exp_t        q[$];

   systolic_array_ctrl #(.ROW(ROW), .COL(COL), .CNT_W(CNT_W)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .num_vec_i       (num_vec_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .w_load_en_o     (w_load_en_o),
      .x_row_en_o      (x_row_en_o),
      .ctrl_load_o     (ctrl_load_o),
      .ctrl_sum_out_o  (ctrl_sum_out_o),
      .ctrl_ps_in_o    (ctrl_ps_in_o),
      .ctrl_ps_valid_o (ctrl_ps_valid_o),
      .south_valid_o   (south_valid_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: output expected p cycles after the start edge of a K-job.
   function automatic snap_t expect_at(int k, int p);
      snap_t s;
      int    len;
      int    t;
      s      = '0;
      s.busy = 1'b1;
      len    = k + ROW + COL - 1;
      if (k == 0) begin
         s.done = 1'b1;
      end else if (p < ROW) begin
         s.wload = 1'b1;
         s.load  = '1;
      end else if (p < ROW + len) begin
         t = p - ROW;
         for (int r = 0; r < ROW; r++) begin
            s.xrow[r] = (t >= r) && (t < r + k);
            for (int c = 0; c < COL; c++) begin
               s.psv[r*COL+c]  = (t >= r + c) && (t < r + c + k);
               s.sum[r*COL+c]  = s.psv[r*COL+c];
               s.psin[r*COL+c] = s.psv[r*COL+c] && (r != 0);
            end
         end
         for (int c = 0; c < COL; c++)
            s.south[c] = (t >= ROW + c) && (t < ROW + c + k);
      end else begin
         s.done = 1'b1;
      end
      return s;
   endfunction

   task automatic push_job(int k, int unsigned drive_cyc);
      exp_t e;
      int   n;
      n = (k == 0) ? 1 : (ROW + (k + ROW + COL - 1) + 1);
      for (int p = 0; p < n; p++) begin
         e.s   = expect_at(k, p);
         e.cyc = drive_cyc + 1 + p;
         q.push_back(e);
      end
   endtask

   // Wait for IDLE (noise on start/num while busy), then request a K-job.
   task automatic run_job(int k, bit hold_start, int gap);
      int waited;
      waited = 0;
      forever begin
         @(posedge clk); #1;
         if (!busy_o && waited >= gap) break;
         start_i   = busy_o ? (hold_start ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
         num_vec_i = CNT_W'($urandom);
         waited++;
         if (waited > 2000) begin
            fails++;
            $display("FAIL idle_timeout: busy_o=%0b after %0d cycles, required 0", busy_o, waited);
            start_i = 1'b0;
            return;
         end
      end
      start_i   = 1'b1;
      num_vec_i = CNT_W'(k);
      push_job(k, cyc);
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      do begin
         @(posedge clk); #1;
         start_i   = 1'b0;
         num_vec_i = CNT_W'($urandom);
         waited++;
      end while ((busy_o || q.size() != 0) && waited < 2000);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected cycles never seen, required 0", q.size());
      end
   endtask

   // Monitor: compare every cycle away from the active edge.
   always @(negedge clk) begin
      snap_t act;
      exp_t  e;
      if (cyc > 0) begin
         act = '{busy: busy_o, done: done_o, wload: w_load_en_o, xrow: x_row_en_o,
                 load: ctrl_load_o, sum: ctrl_sum_out_o, psin: ctrl_ps_in_o,
                 psv: ctrl_ps_valid_o, south: south_valid_o};
         tests++;
         if (busy_o) begin
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_busy: cyc=%0d outputs=%h, required idle", cyc, act);
            end else begin
               e = q.pop_front();
               if (act !== e.s || cyc != e.cyc) begin
                  fails++;
                  $display("FAIL job_cycle: cyc=%0d outputs=%h, required cyc=%0d outputs=%h",
                           cyc, act, e.cyc, e.s);
               end
            end
         end else if (act !== '0) begin
            fails++;
            $display("FAIL idle_zero: cyc=%0d outputs=%h, required 0", cyc, act);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      run_job(3, 1'b0, 2);      // basic latency
      run_job(1, 1'b0, 1);      // single-vector skew
      run_job(0, 1'b0, 1);      // empty job
      run_job(2, 1'b1, 1);      // start held high: one job per IDLE visit
      run_job(2, 1'b1, 0);
      run_job(1, 1'b0, 3);

      // Reset at STREAM t=4 of a K=5 job, then a normal job.
      run_job(5, 1'b0, 1);
      repeat (8) begin
         @(posedge clk); #1;
         start_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i   = 1'b0;
      start_i = 1'b0;
      q.delete();
      run_job(5, 1'b0, 2);

      run_job(255, 1'b0, 1);    // maximum K

      for (int i = 0; i < 20; i++)
         run_job(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));

      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
